mac_reduction_unit: RTL and testbench
=====================================

MAC_REDUCTION_UNIT -- requirements
Module: mac_reduction_unit

Interface
REQ-001 Parameter TILE_SIZE, default 4, tile edge (rows and columns) of each incoming result tile.
REQ-002 Parameter ACC_WIDTH, default 32, width of each incoming tile element.
REQ-003 Parameter COL_BLOCKS, default 16, beats per reduction (column blocks per output vector).
REQ-004 Parameter OUT_WIDTH, default ACC_WIDTH+6, accumulator and output lane width.
REQ-005 Port: clk, input, 1, sole clock; all state changes on rising edge.
REQ-006 Port: rst_n, input, 1, asynchronous active-low reset.
REQ-007 Port: mode, input, 2, operation mode; 2'b00 = MAC, all other values = non-MAC.
REQ-008 Port: in_valid, input, 1, in_tile is valid this cycle (pipeline valid_out); no backpressure exists on this side.
REQ-009 Port: in_tile, input, TILE_SIZE x TILE_SIZE x ACC_WIDTH signed, result tile from the last array stage.
REQ-010 Port: done_tile, input, 1, upstream tile-complete pulse, arrives one cycle after the final beat of a reduction.
REQ-011 Port: out_vec, output, TILE_SIZE x OUT_WIDTH signed, reduced vector.
REQ-012 Port: out_valid, output, 1, out_vec holds an unconsumed result.
REQ-013 Port: out_ready, input, 1, downstream accepts out_vec when out_valid and out_ready are both high.
REQ-014 Port: beat_cnt, output, $clog2(COL_BLOCKS), current beat index.
REQ-015 Port: overflow_err, output, 1, sticky: a result was lost.
REQ-016 Port: sync_err, output, 1, sticky: done_tile disagreed with the internal beat count.

Function
REQ-017 Per beat, the unit SHALL form row sums r[i] = sum over j of in_tile[i][j], sign-extended to OUT_WIDTH, and add r[i] to acc[i].
REQ-018 On beat 0 the unit SHALL load acc[i] = r[i], discarding any prior contents, with no separate clear cycle.
REQ-019 No overflow is possible by construction (4 x 16 = 64 terms; 6 guard bits); no saturation SHALL be applied.
REQ-020 FSM states: IDLE (beat_cnt = 0, no partial sum) and ACCUM (1 to COL_BLOCKS-1 beats absorbed).
- IDLE -> ACCUM on an in_valid beat in MAC mode.
- ACCUM -> IDLE on the beat with beat_cnt = COL_BLOCKS-1 (the final beat).
REQ-021 On the final beat, acc + r SHALL be written into the output register and out_valid SHALL be set on the next cycle; latency from final beat to out_valid is 1 cycle.
REQ-022 out_vec and out_valid SHALL hold steady until the out_valid && out_ready handshake, after which out_valid clears.
REQ-023 If the output register is still valid and not being accepted in the cycle a new result completes, the new result SHALL overwrite it and overflow_err SHALL set.
- A result completing in the same cycle as an accepting handshake is not an overflow; out_valid remains 1 with the new data.
REQ-024 beat_cnt SHALL increment on each MAC in_valid beat and wrap from COL_BLOCKS-1 to 0.
REQ-025 Cycles without in_valid SHALL leave all accumulator state unchanged (gaps are allowed).
REQ-026 sync_err SHALL set if done_tile is high in any cycle not directly following a final beat, or if done_tile is low in the cycle that does directly follow one.
REQ-027 In non-MAC mode:
- in_valid SHALL be ignored.
- beat_cnt, the FSM and the partial sum SHALL be cleared.
- The output register and its handshake SHALL continue to operate.
REQ-028 A mode change mid-reduction SHALL discard the partial sum silently, without setting any error flag.

Reset
REQ-029 While rst_n = 0, asynchronously:
- acc, out_vec, out_valid, beat_cnt, overflow_err and sync_err SHALL all be 0.
- The FSM SHALL be in IDLE.
REQ-030 Reset asserted mid-reduction or with out_valid high SHALL discard all data; the error flags clear only on reset.

Structure
REQ-031 Shared package: mode encoding constants (MAC, EWM, EWA), the TILE_SIZE default, COL_BLOCKS = 256/(TILE_SIZE*4), and the FSM state enum.
REQ-032 One sub-module, tile_row_adder: combinational per-row adder tree, TILE_SIZE x ACC_WIDTH in, TILE_SIZE x OUT_WIDTH out.

Verification
REQ-033 Reset, then mode=00 with 16 beats of all elements = 1 and out_ready = 1 -> out_vec = {64,64,64,64} and out_valid high one cycle after beat 15; done_tile pulsed correctly -> sync_err = 0.
REQ-034 Signed case: 16 beats of element value -1 in row 0 and +2 in row 3 -> out_vec[0] = -64, out_vec[3] = 128.
REQ-035 Backpressure: hold out_ready = 0 and stream 32 beats -> overflow_err = 1 and out_vec holds the second result; repeat with out_ready pulsed at completion -> overflow_err stays 0.
REQ-036 Gaps: 16 beats separated by random idle cycles -> result identical to the gapless run; beat_cnt counts 0..15 and wraps.
REQ-037 Protocol errors: done_tile pulsed after beat 7 -> sync_err = 1; done_tile omitted after beat 15 -> sync_err = 1.
REQ-038 Mode switch to 2'b01 after 5 beats, then back to MAC for 16 beats -> output equals the sum of the later 16 beats only, with no error flags; rst_n pulsed mid-reduction -> all outputs 0 immediately.

Source files
------------

// File: rtl/mac_reduction_unit_pkg.sv
// mac_reduction_unit_pkg
//   Shared definitions for the MAC reduction unit: operating-mode encodings,
//   default tile geometry and the reduction FSM state type.
//   COL_BLOCKS_DEF is the number of column blocks that make up one 256-wide
//   output row when each block is TILE_SIZE columns wide and four tiles
//   are processed per block.

package mac_reduction_unit_pkg;

  localparam logic [1:0] MODE_MAC = 2'b00;
  localparam logic [1:0] MODE_EWM = 2'b01;
  localparam logic [1:0] MODE_EWA = 2'b10;

  localparam int TILE_SIZE_DEF  = 4;
  localparam int COL_BLOCKS_DEF = 256 / (TILE_SIZE_DEF * 4);

  // IDLE: nothing absorbed yet, the next beat loads the accumulator.
  // ACCUM: at least one beat of the current reduction has been absorbed.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } state_e;

endpackage

// File: rtl/mac_reduction_unit_tile_row_adder.sv
// tile_row_adder
//   Purely combinational per-row reduction of one result tile.
//   Ports:
//     in_tile  - TILE_SIZE x TILE_SIZE signed elements, ACC_WIDTH bits each,
//                element [i][j] at bit offset (i*TILE_SIZE+j)*ACC_WIDTH
//     row_sum  - TILE_SIZE signed row sums, OUT_WIDTH bits each,
//                lane i at bit offset i*OUT_WIDTH
//   Every element is sign-extended to OUT_WIDTH before summing so the sum
//   is exact; the sum is written as a simple chain and left to synthesis
//   to balance into a tree.

module tile_row_adder #(
  parameter int TILE_SIZE = 4,
  parameter int ACC_WIDTH = 32,
  parameter int OUT_WIDTH = 38
) (
  input  logic [TILE_SIZE*TILE_SIZE*ACC_WIDTH-1:0] in_tile,
  output logic [TILE_SIZE*OUT_WIDTH-1:0]           row_sum
);

  always_comb begin
    row_sum = '0;
    for (int i = 0; i < TILE_SIZE; i++) begin
      logic signed [OUT_WIDTH-1:0] sum;
      sum = '0;
      for (int j = 0; j < TILE_SIZE; j++) begin
        sum = sum + OUT_WIDTH'($signed(in_tile[(i*TILE_SIZE+j)*ACC_WIDTH +: ACC_WIDTH]));
      end
      row_sum[i*OUT_WIDTH +: OUT_WIDTH] = sum;
    end
  end

endmodule

// File: rtl/mac_reduction_unit.sv
// mac_reduction_unit
//   Reduces a stream of result tiles into one output vector per COL_BLOCKS
//   beats: each beat contributes its row sums to a per-row accumulator, and
//   the final beat of a reduction lands in a single-entry output register.
//   Ports:
//     clk, rst_n    - clock, asynchronous active-low reset
//     mode          - 2'b00 MAC, anything else disables accumulation
//     in_valid      - in_tile carries a beat this cycle (no backpressure)
//     in_tile       - TILE_SIZE x TILE_SIZE x ACC_WIDTH signed, flattened
//     done_tile     - upstream pulse expected one cycle after a final beat
//     out_vec       - TILE_SIZE x OUT_WIDTH signed reduced vector, flattened
//     out_valid     - out_vec holds an unconsumed result
//     out_ready     - downstream accepts out_vec when out_valid is high
//     beat_cnt      - index of the next beat within the current reduction
//     overflow_err  - sticky: an unconsumed result was overwritten
//     sync_err      - sticky: done_tile disagreed with the beat count

module mac_reduction_unit
  import mac_reduction_unit_pkg::*;
#(
  parameter int TILE_SIZE  = TILE_SIZE_DEF,
  parameter int ACC_WIDTH  = 32,
  parameter int COL_BLOCKS = COL_BLOCKS_DEF,
  parameter int OUT_WIDTH  = ACC_WIDTH + 6
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic [1:0]                               mode,
  input  logic                                     in_valid,
  input  logic [TILE_SIZE*TILE_SIZE*ACC_WIDTH-1:0] in_tile,
  input  logic                                     done_tile,
  output logic [TILE_SIZE*OUT_WIDTH-1:0]           out_vec,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic [$clog2(COL_BLOCKS)-1:0]            beat_cnt,
  output logic                                     overflow_err,
  output logic                                     sync_err
);

  localparam int CNT_W = $clog2(COL_BLOCKS);
  localparam int VEC_W = TILE_SIZE * OUT_WIDTH;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [VEC_W-1:0]   acc_q, acc_d;
  logic [VEC_W-1:0]   out_vec_q, out_vec_d;
  logic               out_valid_q, out_valid_d;
  logic               overflow_q, overflow_d;
  logic               sync_q, sync_d;
  logic               last_beat_q, last_beat_d;

  logic [VEC_W-1:0]   row_sum;
  logic [VEC_W-1:0]   sum_new;
  logic               is_mac;
  logic               beat;
  logic               last_beat;
  logic               accept;

  tile_row_adder #(
    .TILE_SIZE (TILE_SIZE),
    .ACC_WIDTH (ACC_WIDTH),
    .OUT_WIDTH (OUT_WIDTH)
  ) u_row_adder (
    .in_tile (in_tile),
    .row_sum (row_sum)
  );

  // The first beat of a reduction loads rather than adds, so a stale
  // accumulator never needs a dedicated clear cycle.
  always_comb begin
    sum_new = '0;
    for (int i = 0; i < TILE_SIZE; i++) begin
      sum_new[i*OUT_WIDTH +: OUT_WIDTH] =
        ((state_q == ST_IDLE) ? '0 : acc_q[i*OUT_WIDTH +: OUT_WIDTH])
        + row_sum[i*OUT_WIDTH +: OUT_WIDTH];
    end
  end

  always_comb begin
    is_mac    = (mode == MODE_MAC);
    beat      = in_valid && is_mac;
    last_beat = beat && (beat_cnt_q == CNT_W'(COL_BLOCKS - 1));
    accept    = out_valid_q && out_ready;

    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    acc_d       = acc_q;
    out_vec_d   = out_vec_q;
    out_valid_d = out_valid_q;
    overflow_d  = overflow_q;
    sync_d      = sync_q;
    last_beat_d = last_beat;

    // Leaving MAC mode silently abandons any partial reduction.
    if (!is_mac) begin
      state_d    = ST_IDLE;
      beat_cnt_d = '0;
      acc_d      = '0;
    end else if (beat) begin
      acc_d = sum_new;
      if (last_beat) begin
        state_d    = ST_IDLE;
        beat_cnt_d = '0;
      end else begin
        state_d    = ST_ACCUM;
        beat_cnt_d = beat_cnt_q + 1'b1;
      end
    end

    // A completing result always wins the output register; it only counts
    // as lost data when the old result is neither consumed nor accepted now.
    if (last_beat) begin
      out_vec_d   = sum_new;
      out_valid_d = 1'b1;
      if (out_valid_q && !out_ready) begin
        overflow_d = 1'b1;
      end
    end else if (accept) begin
      out_valid_d = 1'b0;
    end

    // done_tile must track the registered final-beat marker exactly.
    if (done_tile != last_beat_q) begin
      sync_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      beat_cnt_q  <= '0;
      acc_q       <= '0;
      out_vec_q   <= '0;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      sync_q      <= 1'b0;
      last_beat_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      acc_q       <= acc_d;
      out_vec_q   <= out_vec_d;
      out_valid_q <= out_valid_d;
      overflow_q  <= overflow_d;
      sync_q      <= sync_d;
      last_beat_q <= last_beat_d;
    end
  end

  assign out_vec      = out_vec_q;
  assign out_valid    = out_valid_q;
  assign beat_cnt     = beat_cnt_q;
  assign overflow_err = overflow_q;
  assign sync_err     = sync_q;

endmodule

// File: tb/tb_mac_reduction_unit.sv
// tb_mac_reduction_unit
//   Directed scenarios with randomized tile contents, checked every cycle
//   against a beat-level arithmetic model of the reduction.

module tb_mac_reduction_unit;

  localparam int TS = 4;
  localparam int AW = 32;
  localparam int CB = 16;
  localparam int OW = AW + 6;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [1:0]            mode;
  logic                  in_valid;
  logic [TS*TS*AW-1:0]   in_tile;
  logic                  done_tile;
  logic [TS*OW-1:0]      out_vec;
  logic                  out_valid;
  logic                  out_ready;
  logic [3:0]            beat_cnt;
  logic                  overflow_err;
  logic                  sync_err;

  always #5 clk = ~clk;

  mac_reduction_unit #(
    .TILE_SIZE  (TS),
    .ACC_WIDTH  (AW),
    .COL_BLOCKS (CB),
    .OUT_WIDTH  (OW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mode         (mode),
    .in_valid     (in_valid),
    .in_tile      (in_tile),
    .done_tile    (done_tile),
    .out_vec      (out_vec),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .beat_cnt     (beat_cnt),
    .overflow_err (overflow_err),
    .sync_err     (sync_err)
  );

  // Reference model state: running row totals, beats taken, last result.
  longint m_acc [TS];
  longint m_out [TS];
  longint saved_out [TS];
  int     m_beats;
  bit     m_valid;
  bit     m_ovf;
  bit     m_sync;
  bit     done_due;
  int     done_force;

  int     n_checks;
  int     n_errors;

  logic [TS*TS*AW-1:0] tiles [CB];

  function automatic longint elem(int i, int j);
    return longint'($signed(in_tile[(i*TS+j)*AW +: AW]));
  endfunction

  function automatic logic signed [63:0] lane(int i);
    logic signed [63:0] v;
    v = $signed(out_vec[i*OW +: OW]);
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < TS; i++) begin
      m_acc[i] = 0;
      m_out[i] = 0;
    end
    m_beats  = 0;
    m_valid  = 1'b0;
    m_ovf    = 1'b0;
    m_sync   = 1'b0;
    done_due = 1'b0;
  endtask

  task automatic checkValue(input string tag, input logic signed [63:0] obs,
                            input logic signed [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkValue({tag, ".out_valid"}, out_valid, m_valid);
    checkValue({tag, ".beat_cnt"}, beat_cnt, m_beats);
    checkValue({tag, ".overflow_err"}, overflow_err, m_ovf);
    checkValue({tag, ".sync_err"}, sync_err, m_sync);
    if (m_valid) begin
      for (int i = 0; i < TS; i++) begin
        checkValue($sformatf("%s.out_vec[%0d]", tag, i), lane(i), m_out[i]);
      end
    end
  endtask

  // One clock cycle: drive at the falling edge, advance the model by what
  // the upcoming rising edge should do, then settle just past that edge.
  task automatic applyStimulus(input bit v);
    bit     done_now;
    bit     completed;
    bit     accept;
    longint r;
    @(negedge clk);
    in_valid  = v;
    done_tile = (done_force < 0) ? done_due : done_force[0];
    done_force = -1;
    if (done_tile !== done_due) m_sync = 1'b1;
    done_now  = 1'b0;
    completed = 1'b0;
    accept    = m_valid && out_ready;
    if (mode == 2'b00) begin
      if (v) begin
        for (int i = 0; i < TS; i++) begin
          r = 0;
          for (int j = 0; j < TS; j++) r += elem(i, j);
          m_acc[i] = ((m_beats == 0) ? 0 : m_acc[i]) + r;
        end
        m_beats++;
        if (m_beats == CB) begin
          if (m_valid && !out_ready) m_ovf = 1'b1;
          m_out     = m_acc;
          m_valid   = 1'b1;
          m_beats   = 0;
          completed = 1'b1;
          done_now  = 1'b1;
        end
      end
    end else begin
      m_beats = 0;
    end
    if (!completed && accept) m_valid = 1'b0;
    done_due = done_now;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    done_tile = 1'b0;
    #1;
    model_reset();
    checkOutput("reset");
    for (int i = 0; i < TS; i++) checkValue($sformatf("reset.out_vec[%0d]", i), lane(i), 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic fill_const(input longint v);
    for (int i = 0; i < TS; i++)
      for (int j = 0; j < TS; j++)
        in_tile[(i*TS+j)*AW +: AW] = AW'(v);
  endtask

  task automatic fill_rand();
    for (int k = 0; k < TS*TS; k++) in_tile[k*AW +: AW] = $urandom;
  endtask

  task automatic run_beats(input int n, input int gap_max, input bit rnd, input string tag);
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, gap_max)) begin
        applyStimulus(1'b0);
        checkOutput({tag, ".gap"});
      end
      if (rnd) fill_rand();
      applyStimulus(1'b1);
      checkOutput({tag, ".beat"});
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    done_force = -1;
    rst_n      = 1'b0;
    mode       = 2'b00;
    in_valid   = 1'b0;
    done_tile  = 1'b0;
    out_ready  = 1'b1;
    in_tile    = '0;
    model_reset();
    do_reset();

    // All-ones tiles: every row sums to 4 per beat, 64 after 16 beats.
    out_ready = 1'b1;
    fill_const(1);
    run_beats(CB, 0, 1'b0, "ones");
    checkValue("ones.valid_after_last", out_valid, 1);
    for (int i = 0; i < TS; i++) checkValue($sformatf("ones.lane%0d", i), lane(i), 64);
    applyStimulus(1'b0);
    checkOutput("ones.done");
    checkValue("ones.sync_err", sync_err, 0);

    // Signed rows: row 0 all -1, row 3 all +2.
    fill_const(0);
    for (int j = 0; j < TS; j++) begin
      in_tile[(0*TS+j)*AW +: AW] = '1;
      in_tile[(3*TS+j)*AW +: AW] = AW'(2);
    end
    run_beats(CB, 0, 1'b0, "signed");
    checkValue("signed.lane0", lane(0), -64);
    checkValue("signed.lane3", lane(3), 128);
    applyStimulus(1'b0);
    checkOutput("signed.done");

    // Backpressure: two results with nobody accepting loses the first.
    out_ready = 1'b0;
    run_beats(2*CB, 0, 1'b1, "bp");
    checkValue("bp.overflow_err", overflow_err, 1);
    applyStimulus(1'b0);
    checkOutput("bp.done");
    out_ready = 1'b1;
    applyStimulus(1'b0);
    checkOutput("bp.drain");
    do_reset();

    // Accept coinciding with the second completion is not an overflow.
    out_ready = 1'b0;
    run_beats(2*CB - 1, 0, 1'b1, "bp2");
    out_ready = 1'b1;
    fill_rand();
    applyStimulus(1'b1);
    checkOutput("bp2.last");
    checkValue("bp2.overflow_err", overflow_err, 0);
    checkValue("bp2.out_valid", out_valid, 1);
    applyStimulus(1'b0);
    checkOutput("bp2.drain");

    // Gapless reference run over a fixed tile sequence.
    for (int k = 0; k < CB; k++) begin
      fill_rand();
      tiles[k] = in_tile;
    end
    for (int k = 0; k < CB; k++) begin
      in_tile = tiles[k];
      applyStimulus(1'b1);
      checkOutput("nogap.beat");
    end
    saved_out = m_out;
    applyStimulus(1'b0);
    checkOutput("nogap.done");

    // Same tiles with random idle gaps: identical result, count wraps.
    for (int k = 0; k < CB; k++) begin
      repeat ($urandom_range(0, 3)) begin
        applyStimulus(1'b0);
        checkOutput("gap.idle");
      end
      in_tile = tiles[k];
      applyStimulus(1'b1);
      checkOutput("gap.beat");
      checkValue("gap.beat_cnt", beat_cnt, (k + 1) % CB);
    end
    for (int i = 0; i < TS; i++) checkValue($sformatf("gap.same_lane%0d", i), lane(i), saved_out[i]);
    applyStimulus(1'b0);
    checkOutput("gap.done");

    // Spurious done_tile mid-reduction.
    run_beats(8, 0, 1'b1, "sync1");
    done_force = 1;
    applyStimulus(1'b0);
    checkOutput("sync1.spurious");
    checkValue("sync1.sync_err", sync_err, 1);
    do_reset();

    // Missing done_tile after the final beat.
    run_beats(CB, 0, 1'b1, "sync2");
    done_force = 0;
    applyStimulus(1'b0);
    checkOutput("sync2.missing");
    checkValue("sync2.sync_err", sync_err, 1);
    do_reset();

    // Mode switch discards the partial sum without flagging anything.
    run_beats(5, 0, 1'b1, "msw.pre");
    mode = 2'b01;
    run_beats(2, 0, 1'b1, "msw.ewm");
    checkValue("msw.beat_cnt", beat_cnt, 0);
    mode = 2'b00;
    run_beats(CB, 1, 1'b1, "msw.post");
    applyStimulus(1'b0);
    checkOutput("msw.done");
    checkValue("msw.overflow_err", overflow_err, 0);
    checkValue("msw.sync_err", sync_err, 0);

    // Reset while a result is pending and a reduction is half done.
    out_ready = 1'b0;
    run_beats(CB, 0, 1'b1, "rst.full");
    applyStimulus(1'b0);
    checkOutput("rst.done");
    run_beats(6, 0, 1'b1, "rst.partial");
    do_reset();
    out_ready = 1'b1;
    run_beats(CB, 0, 1'b1, "rst.after");
    applyStimulus(1'b0);
    checkOutput("rst.after_done");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
